// File: rtl/pc_pkg.sv
// Shared types and default vectors for the PC generation unit.
// Imported by the PC unit, its interface and the RAS.
package pc_pkg;

  localparam int unsigned DEF_WIDTH     = 32;
  localparam int unsigned DEF_INC       = 4;
  localparam int unsigned DEF_RAS_DEPTH = 4;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0180;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_EXC  = 3'd0,
    SEL_JR   = 3'd1,
    SEL_BR   = 3'd2,
    SEL_J    = 3'd3,
    SEL_SEQ  = 3'd4,
    SEL_HOLD = 3'd5
  } pc_sel_t;

endpackage

// File: rtl/pc_gen_unit_if.sv
// Fetch, redirect and RAS bundle between the PC unit and its users.
// slave is the PC unit side, master the driving side.
interface pc_gen_if
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
);

  logic             FetchReady;
  logic             FetchValid;
  logic [WIDTH-1:0] PC;
  logic [WIDTH-1:0] PCPlusInc;
  logic             Exception;
  logic             JRValid;
  logic [WIDTH-1:0] JRTarget;
  logic             BranchTaken;
  logic [WIDTH-1:0] BranchTarget;
  logic             JumpValid;
  logic [WIDTH-1:0] JumpTarget;
  logic             Halt;
  logic             Resume;
  logic             AlignErr;
  logic             RasPush;
  logic [WIDTH-1:0] RasPushAddr;
  logic             RasPop;
  logic [WIDTH-1:0] RasTop;
  logic             RasEmpty;

  modport master (
    output FetchReady, Exception,
    output JRValid, JRTarget,
    output BranchTaken, BranchTarget,
    output JumpValid, JumpTarget,
    output Halt, Resume,
    output RasPush, RasPushAddr, RasPop,
    input  FetchValid, PC, PCPlusInc,
    input  AlignErr, RasTop, RasEmpty
  );

  modport slave (
    input  FetchReady, Exception,
    input  JRValid, JRTarget,
    input  BranchTaken, BranchTarget,
    input  JumpValid, JumpTarget,
    input  Halt, Resume,
    input  RasPush, RasPushAddr, RasPop,
    output FetchValid, PC, PCPlusInc,
    output AlignErr, RasTop, RasEmpty
  );

endinterface

// File: rtl/pc_ras.sv
// Circular return-address stack with a saturating occupancy count.
// When full, a push silently overwrites the oldest entry.
module pc_ras
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_addr,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_top,
  output logic             o_empty
);

  localparam int unsigned PW = $clog2(RAS_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [RAS_DEPTH];
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_top_idx;
  logic [CW-1:0]    r_cnt;
  logic             w_empty;
  logic             w_full;
  logic             w_push;
  logic             w_repl;
  logic             w_pop;

  assign w_top_idx = r_ptr - PW'(1);
  assign w_empty   = (r_cnt == '0);
  assign w_full    = (r_cnt == CW'(RAS_DEPTH));

  // Push+pop on an empty stack degrades to a plain push.
  assign w_push = i_push & (~i_pop | w_empty) & ~i_clear;
  assign w_repl = i_push & i_pop & ~w_empty & ~i_clear;
  assign w_pop  = i_pop & ~i_push & ~w_empty & ~i_clear;

  // Pointer and occupancy; clear wins over push/pop
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_ptr <= '0;
      r_cnt <= '0;
    end else if (w_push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!w_full) r_cnt <= r_cnt + CW'(1);
    end else if (w_pop) begin
      r_ptr <= w_top_idx;
      r_cnt <= r_cnt - CW'(1);
    end
  end

  // Entry storage; contents past the count are never observed
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_ptr] <= i_push_addr;
    else if (w_repl) r_mem[w_top_idx] <= i_push_addr;
  end

  assign o_top   = w_empty ? '0 : r_mem[w_top_idx];
  assign o_empty = w_empty;

endmodule

// File: rtl/pc_gen_unit.sv
// IF-stage program counter: next-PC priority mux, fetch FSM,
// redirect alignment check and return-address stack.
module pc_gen_unit
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH        = DEF_WIDTH,
  parameter int unsigned      INC          = DEF_INC,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
  parameter int unsigned      RAS_DEPTH    = DEF_RAS_DEPTH
) (
  input logic     Clk,
  input logic     Reset,
  pc_gen_if.slave bus
);

  localparam logic [WIDTH-1:0] INC_W = WIDTH'(INC);
  localparam logic [WIDTH-1:0] MASK  = WIDTH'(INC - 1);

  pc_state_t        r_state;
  pc_state_t        w_state_nxt;
  pc_sel_t          w_sel;
  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] w_pc_nxt;
  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_tgt;
  logic             w_use_tgt;
  logic             r_align_err;
  logic             w_align_nxt;
  logic             w_redirect;
  logic             w_fetch_valid;

  assign w_redirect = bus.Exception | bus.JRValid |
                      bus.BranchTaken | bus.JumpValid;
  assign w_pc_inc   = r_pc + INC_W;

  // FSM state register
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) r_state <= ST_BOOT;
    else        r_state <= w_state_nxt;
  end

  // FSM next state; a redirect in the same cycle defers a halt
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT:
        w_state_nxt = ST_RUN;
      ST_RUN:
        if (bus.Halt && !w_redirect) w_state_nxt = ST_HALTED;
      ST_HALTED:
        if (bus.Exception || bus.Resume) w_state_nxt = ST_RUN;
      default:
        w_state_nxt = ST_BOOT;
    endcase
  end

  // FSM outputs
  always_comb begin
    w_fetch_valid = (r_state == ST_RUN);
  end

  // Next-PC source; halted only reacts to exceptions
  always_comb begin
    w_sel = SEL_HOLD;
    if (r_state == ST_RUN) begin
      priority case (1'b1)
        bus.Exception:                  w_sel = SEL_EXC;
        bus.JRValid:                    w_sel = SEL_JR;
        bus.BranchTaken:                w_sel = SEL_BR;
        bus.JumpValid:                  w_sel = SEL_J;
        w_fetch_valid & bus.FetchReady: w_sel = SEL_SEQ;
        default:                        w_sel = SEL_HOLD;
      endcase
    end else if (r_state == ST_HALTED && bus.Exception) begin
      w_sel = SEL_EXC;
    end
  end

  // Target mux; misaligned targets are diverted to the handler
  always_comb begin
    w_tgt     = r_pc;
    w_use_tgt = 1'b0;
    case (w_sel)
      SEL_JR: begin
        w_tgt     = bus.JRTarget;
        w_use_tgt = 1'b1;
      end
      SEL_BR: begin
        w_tgt     = bus.BranchTarget;
        w_use_tgt = 1'b1;
      end
      SEL_J: begin
        w_tgt     = bus.JumpTarget;
        w_use_tgt = 1'b1;
      end
      default: ;
    endcase
    w_align_nxt = w_use_tgt && ((w_tgt & MASK) != '0);
    w_pc_nxt    = r_pc;
    case (w_sel)
      SEL_EXC:  w_pc_nxt = EXC_VECTOR;
      SEL_SEQ:  w_pc_nxt = w_pc_inc;
      SEL_HOLD: w_pc_nxt = r_pc;
      default:  w_pc_nxt = w_align_nxt ? EXC_VECTOR : w_tgt;
    endcase
  end

  // PC register and alignment-error pulse
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_pc        <= RESET_VECTOR;
      r_align_err <= 1'b0;
    end else begin
      r_pc        <= w_pc_nxt;
      r_align_err <= w_align_nxt;
    end
  end

  pc_ras #(
    .WIDTH     (WIDTH),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .i_clk       (Clk),
    .i_rst_n     (Reset),
    .i_clear     (bus.Exception),
    .i_push      (bus.RasPush),
    .i_push_addr (bus.RasPushAddr),
    .i_pop       (bus.RasPop),
    .o_top       (bus.RasTop),
    .o_empty     (bus.RasEmpty)
  );

  assign bus.FetchValid = w_fetch_valid;
  assign bus.PC         = r_pc;
  assign bus.PCPlusInc  = w_pc_inc;
  assign bus.AlignErr   = r_align_err;

endmodule

// File: tb/tb_pc_gen_unit.sv
// Bench for pc_gen_unit: directed scenarios plus a randomized run
// against a behavioural model of the fetch/redirect/RAS rules.
module tb_pc_gen_unit;

  localparam logic [31:0] EXC = 32'h0000_0180;
  localparam int          DEPTH = 4;

  logic clk;
  logic rst_n;

  int n_vec;
  int n_err;

  pc_gen_if #(.WIDTH(32)) bus ();

  pc_gen_unit #(
    .WIDTH        (32),
    .INC          (4),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (EXC),
    .RAS_DEPTH    (DEPTH)
  ) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state
  logic [31:0] m_pc;
  bit          m_boot;
  bit          m_halt;
  bit          m_align;
  logic [31:0] ras_q[$];

  task automatic clear_inputs();
    bus.FetchReady   = 1'b0;
    bus.Exception    = 1'b0;
    bus.JRValid      = 1'b0;
    bus.JRTarget     = '0;
    bus.BranchTaken  = 1'b0;
    bus.BranchTarget = '0;
    bus.JumpValid    = 1'b0;
    bus.JumpTarget   = '0;
    bus.Halt         = 1'b0;
    bus.Resume       = 1'b0;
    bus.RasPush      = 1'b0;
    bus.RasPushAddr  = '0;
    bus.RasPop       = 1'b0;
  endtask

  task automatic model_reset();
    m_pc    = 32'h0;
    m_boot  = 1'b1;
    m_halt  = 1'b0;
    m_align = 1'b0;
    ras_q.delete();
  endtask

  // Apply the documented rules to the inputs present this cycle.
  task automatic model_step();
    logic [31:0] t;
    bit redir;
    redir = bus.Exception | bus.JRValid | bus.BranchTaken | bus.JumpValid;
    if (bus.Exception) ras_q.delete();
    else if (bus.RasPush && bus.RasPop && ras_q.size() > 0)
      ras_q[ras_q.size()-1] = bus.RasPushAddr;
    else if (bus.RasPush) begin
      if (ras_q.size() == DEPTH) void'(ras_q.pop_front());
      ras_q.push_back(bus.RasPushAddr);
    end else if (bus.RasPop && ras_q.size() > 0)
      void'(ras_q.pop_back());
    m_align = 1'b0;
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (m_halt) begin
      if (bus.Exception) begin
        m_pc   = EXC;
        m_halt = 1'b0;
      end else if (bus.Resume) m_halt = 1'b0;
    end else begin
      if (bus.Exception) m_pc = EXC;
      else if (bus.JRValid | bus.BranchTaken | bus.JumpValid) begin
        t = bus.JRValid ? bus.JRTarget :
            bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
        if (t % 4 != 0) begin
          m_pc    = EXC;
          m_align = 1'b1;
        end else m_pc = t;
      end else if (bus.FetchReady) m_pc = m_pc + 32'd4;
      if (bus.Halt && !redir) m_halt = 1'b1;
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    n_vec++;
    if (bus.FetchValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_fv: got %b want 0", bus.FetchValid);
    end
    n_vec++;
    if (bus.PC !== 32'h0 || bus.AlignErr !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pc: got %h/%b want 0/0", bus.PC, bus.AlignErr);
    end
    n_vec++;
    if (bus.RasEmpty !== 1'b1 || bus.RasTop !== 32'h0) begin
      n_err++;
      $display("FAIL reset_ras: got %b/%h want 1/0", bus.RasEmpty, bus.RasTop);
    end
  endtask

  task automatic test_sequential();
    bus.FetchReady = 1'b1;
    tick();
    n_vec++;
    if (bus.PC !== 32'h0 || bus.FetchValid !== 1'b1) begin
      n_err++;
      $display("FAIL boot_run: got %h/%b want 0/1", bus.PC, bus.FetchValid);
    end
    for (int i = 1; i <= 3; i++) begin
      tick();
      n_vec++;
      if (bus.PC !== 32'(4 * i) || bus.PCPlusInc !== 32'(4 * i + 4)) begin
        n_err++;
        $display("FAIL seq_%0d: got %h/%h want %h/%h", i, bus.PC,
                 bus.PCPlusInc, 32'(4 * i), 32'(4 * i + 4));
      end
    end
  endtask

  task automatic test_stall_redirect();
    bus.FetchReady = 1'b0;
    bus.JumpValid  = 1'b1;
    bus.JumpTarget = 32'h10;
    tick();
    bus.JumpValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (bus.PC !== 32'h10 || bus.FetchValid !== 1'b1) begin
        n_err++;
        $display("FAIL stall_%0d: got %h/%b want 10/1", i, bus.PC, bus.FetchValid);
      end
    end
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h40;
    tick();
    bus.BranchTaken = 1'b0;
    n_vec++;
    if (bus.PC !== 32'h40) begin
      n_err++;
      $display("FAIL stall_branch: got %h want 40", bus.PC);
    end
  endtask

  task automatic test_priority_align();
    bus.RasPush     = 1'b1;
    bus.RasPushAddr = 32'h1234;
    tick();
    bus.RasPush = 1'b0;
    n_vec++;
    if (bus.RasTop !== 32'h1234 || bus.RasEmpty !== 1'b0) begin
      n_err++;
      $display("FAIL ras_push1: got %h/%b want 1234/0", bus.RasTop, bus.RasEmpty);
    end
    bus.Exception    = 1'b1;
    bus.JRValid      = 1'b1;
    bus.JRTarget     = 32'h100;
    bus.BranchTaken  = 1'b1;
    bus.BranchTarget = 32'h200;
    tick();
    clear_inputs();
    n_vec++;
    if (bus.PC !== EXC || bus.RasEmpty !== 1'b1 || bus.AlignErr !== 1'b0) begin
      n_err++;
      $display("FAIL exc_prio: got %h/%b/%b want 180/1/0", bus.PC,
               bus.RasEmpty, bus.AlignErr);
    end
    bus.JRValid  = 1'b1;
    bus.JRTarget = 32'h102;
    tick();
    bus.JRValid = 1'b0;
    n_vec++;
    if (bus.PC !== EXC || bus.AlignErr !== 1'b1) begin
      n_err++;
      $display("FAIL misalign: got %h/%b want 180/1", bus.PC, bus.AlignErr);
    end
    tick();
    n_vec++;
    if (bus.AlignErr !== 1'b0 || bus.PC !== EXC) begin
      n_err++;
      $display("FAIL align_pulse: got %b/%h want 0/180", bus.AlignErr, bus.PC);
    end
  endtask

  task automatic test_halt();
    bus.JumpValid  = 1'b1;
    bus.JumpTarget = 32'h20;
    tick();
    bus.JumpValid = 1'b0;
    bus.Halt      = 1'b1;
    tick();
    bus.Halt = 1'b0;
    n_vec++;
    if (bus.PC !== 32'h20 || bus.FetchValid !== 1'b0) begin
      n_err++;
      $display("FAIL halt: got %h/%b want 20/0", bus.PC, bus.FetchValid);
    end
    bus.JumpValid  = 1'b1;
    bus.JumpTarget = 32'h80;
    tick();
    bus.JumpValid = 1'b0;
    n_vec++;
    if (bus.PC !== 32'h20 || bus.FetchValid !== 1'b0) begin
      n_err++;
      $display("FAIL halt_jump: got %h/%b want 20/0", bus.PC, bus.FetchValid);
    end
    bus.Resume = 1'b1;
    tick();
    bus.Resume = 1'b0;
    n_vec++;
    if (bus.PC !== 32'h20 || bus.FetchValid !== 1'b1) begin
      n_err++;
      $display("FAIL resume: got %h/%b want 20/1", bus.PC, bus.FetchValid);
    end
  endtask

  task automatic test_ras();
    logic [31:0] vals [5];
    for (int i = 0; i < 5; i++) vals[i] = 32'hA000 + 32'(i * 16);
    for (int i = 0; i < 5; i++) begin
      bus.RasPush     = 1'b1;
      bus.RasPushAddr = vals[i];
      tick();
    end
    bus.RasPush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (bus.RasTop !== vals[4-i]) begin
        n_err++;
        $display("FAIL ras_pop_%0d: got %h want %h", i, bus.RasTop, vals[4-i]);
      end
      bus.RasPop = 1'b1;
      tick();
      bus.RasPop = 1'b0;
    end
    n_vec++;
    if (bus.RasEmpty !== 1'b1 || bus.RasTop !== 32'h0) begin
      n_err++;
      $display("FAIL ras_drained: got %b/%h want 1/0", bus.RasEmpty, bus.RasTop);
    end
    bus.RasPop = 1'b1;
    tick();
    bus.RasPop = 1'b0;
    n_vec++;
    if (bus.RasEmpty !== 1'b1 || bus.RasTop !== 32'h0) begin
      n_err++;
      $display("FAIL ras_pop_empty: got %b/%h want 1/0", bus.RasEmpty, bus.RasTop);
    end
    bus.RasPush     = 1'b1;
    bus.RasPushAddr = 32'hB000;
    tick();
    bus.RasPop      = 1'b1;
    bus.RasPushAddr = 32'hC000;
    tick();
    clear_inputs();
    n_vec++;
    if (bus.RasTop !== 32'hC000 || bus.RasEmpty !== 1'b0) begin
      n_err++;
      $display("FAIL ras_replace: got %h/%b want c000/0", bus.RasTop, bus.RasEmpty);
    end
    bus.RasPop = 1'b1;
    tick();
    bus.RasPop = 1'b0;
    n_vec++;
    if (bus.RasEmpty !== 1'b1) begin
      n_err++;
      $display("FAIL ras_repl_count: got %b want 1", bus.RasEmpty);
    end
  endtask

  task automatic test_wrap_async_reset();
    bus.JumpValid  = 1'b1;
    bus.JumpTarget = 32'hFFFF_FFFC;
    tick();
    bus.JumpValid = 1'b0;
    n_vec++;
    if (bus.PCPlusInc !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_inc: got %h want 0", bus.PCPlusInc);
    end
    bus.FetchReady = 1'b1;
    tick();
    bus.FetchReady = 1'b0;
    n_vec++;
    if (bus.PC !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_pc: got %h want 0", bus.PC);
    end
    bus.JumpValid  = 1'b1;
    bus.JumpTarget = 32'h40;
    bus.RasPush    = 1'b1;
    tick();
    clear_inputs();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if (bus.PC !== 32'h0 || bus.FetchValid !== 1'b0 || bus.RasEmpty !== 1'b1) begin
      n_err++;
      $display("FAIL async_reset: got %h/%b/%b want 0/0/1", bus.PC,
               bus.FetchValid, bus.RasEmpty);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] exp_top;
    for (int c = 0; c < 400; c++) begin
      bus.FetchReady   = ($urandom_range(3) != 0);
      bus.Exception    = ($urandom_range(19) == 0);
      bus.JRValid      = ($urandom_range(9) == 0);
      bus.BranchTaken  = ($urandom_range(7) == 0);
      bus.JumpValid    = ($urandom_range(9) == 0);
      bus.JRTarget     = $urandom & (($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      bus.BranchTarget = $urandom & (($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      bus.JumpTarget   = $urandom & (($urandom_range(7) == 0) ? 32'hFFFF_FFFF : 32'hFFFF_FFFC);
      bus.Halt         = ($urandom_range(9) == 0);
      bus.Resume       = ($urandom_range(3) == 0);
      bus.RasPush      = ($urandom_range(3) == 0);
      bus.RasPop       = ($urandom_range(3) == 0);
      bus.RasPushAddr  = $urandom;
      tick();
      exp_top = (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : 32'h0;
      n_vec++;
      if (bus.PC !== m_pc || bus.PCPlusInc !== m_pc + 32'd4) begin
        n_err++;
        $display("FAIL rnd_pc c%0d: got %h/%h want %h/%h", c, bus.PC,
                 bus.PCPlusInc, m_pc, m_pc + 32'd4);
      end
      n_vec++;
      if (bus.FetchValid !== !(m_boot || m_halt) || bus.AlignErr !== m_align) begin
        n_err++;
        $display("FAIL rnd_ctl c%0d: got fv %b ae %b want %b %b", c,
                 bus.FetchValid, bus.AlignErr, !(m_boot || m_halt), m_align);
      end
      n_vec++;
      if (bus.RasTop !== exp_top || bus.RasEmpty !== (ras_q.size() == 0)) begin
        n_err++;
        $display("FAIL rnd_ras c%0d: got %h/%b want %h/%b", c, bus.RasTop,
                 bus.RasEmpty, exp_top, ras_q.size() == 0);
      end
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_sequential();
    test_stall_redirect();
    test_priority_align();
    test_halt();
    test_ras();
    test_wrap_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
